noc_inject_port: RTL and testbench
==================================

Name: noc_inject_port

Overview:
- Router-side responder for the client injection handshake (i_v / i_ack), i.e. the NoC end that client packet sources drive.
- Accepts one packet per handshake from a client and buffers it in a small show-ahead FIFO.
- Presents buffered packets to the local router input with a valid/ready interface.
- Keeps an accepted-packet count and a busy indication, so the bench can match "S" trace lines against router-side departures.

Parameters:
- VC_W, 2, virtual-channel field width
- X_W, 2, destination X field width
- Y_W, 2, destination Y field width
- D_W, 28, payload width
- DEPTH, 4, FIFO entries; power of two, >=2
- CNT_W, 16, accepted-packet counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- i_v  in  1  client packet valid; held high until acked
- i_vc  in  VC_W  packet virtual channel
- i_x  in  X_W  destination X
- i_y  in  Y_W  destination Y
- i_data  in  D_W  payload
- i_b  in  VC_W  reserved; clients tie it to 0; ignored
- i_ack  out  1  single-cycle acknowledge of the presented packet
- r_v  out  1  head-of-FIFO valid toward router
- r_ready  in  1  router accepts head this cycle
- r_vc  out  VC_W  head virtual channel
- r_x  out  X_W  head destination X
- r_y  out  Y_W  head destination Y
- r_data  out  D_W  head payload
- occ  out  $clog2(DEPTH)+1  current FIFO occupancy
- acc_cnt  out  CNT_W  packets accepted since reset
- busy  out  1  occ != 0 or an ack is pending

Behaviour:
- Reset (rst=0, async): FIFO empty, occ=0, i_ack=0, r_v=0, r_vc/r_x/r_y/r_data=0, acc_cnt=0, busy=0. Reset mid-operation discards all buffered packets immediately.
- Packet word = {vc,x,y,data}, VC in the MSBs, stored unmodified.
- Accept condition, evaluated each cycle: acc = i_v && !i_ack && (occ < DEPTH || pop).
  - pop = r_v && r_ready, so a full FIFO with a same-cycle pop still accepts.
- On acc:
  - write the packet at wr_ptr and advance wr_ptr.
  - i_ack <= 1 for exactly the next cycle; acc_cnt <= acc_cnt+1.
- The client keeps i_v high during the ack cycle. The !i_ack term blocks re-accepting the same packet; that cycle is dead for acceptance.
- Back-to-back rate: one packet per 2 cycles maximum. This matches a client that loads its next packet on the ack edge.
- Latency: i_v first high at cycle t with space -> i_ack high at t+1 -> r_v high at t+1 if the FIFO was empty (write visible to head on the next edge).
- Full without pop: acc=0, i_ack stays 0, the client waits with i_v held. No packet is dropped or overwritten.
- Pop: on r_v && r_ready, advance rd_ptr.
  - Head outputs are the show-ahead view of FIFO[rd_ptr], held stable while r_v && !r_ready.
  - r_v = (occ != 0).
- Simultaneous push and pop: occ unchanged. On an empty FIFO, a push cannot be popped in the same cycle (no bypass).
- Pointers are log2(DEPTH) bits and wrap naturally. occ is tracked separately, so full and empty are unambiguous.
- acc_cnt wraps modulo 2^CNT_W with no saturation.
- busy = (occ != 0) || i_ack.
- i_v low: no state change on the input side. i_vc/i_x/i_y/i_data/i_b are don't-care.

Decomposition:
- Package noc_pkg:
  - VC_W, X_W, Y_W, D_W defaults.
  - Packed struct pkt_t {vc,x,y,data}.
  - Field helper functions replacing the backtick field macros.
- Sub-module sync_fifo (DEPTH, WIDTH): show-ahead, push/pop/occ, async active-low reset. noc_inject_port instantiates one with WIDTH = $bits(pkt_t).
- Handshake/ack logic and counter live in the top.

Test Plan:
- Single packet: i_v=1, vc=1, x=2, y=3, data=0xABCDEF0 at cycle 5, r_ready=1 -> i_ack=1 only at cycle 6; r_v=1 at 6 with identical fields; popped at 6; acc_cnt=1; occ back to 0 at 7.
- Held i_v during ack: i_v stays high through cycle 6 with the same packet -> exactly one write, acc_cnt=1 (no duplicate).
- Backpressure to full, DEPTH=4, r_ready=0: 6 packets offered back-to-back -> 4 acks at cycles t+1, t+3, t+5, t+7; occ=4; 5th i_v held with no ack. Raising r_ready -> 5th acked the cycle after the first pop edge. Order preserved 1..6.
- Full with simultaneous pop: occ=4, r_ready=1, i_v=1 -> accept and pop in the same edge, occ stays 4, i_ack next cycle.
- Wrap-around: 128 packets with random r_ready (50%) -> router-side sequence equals input sequence; acc_cnt=128; pointers wrap 32 times without error.
- Async reset mid-stream: drive rst=0 off-edge with occ=3 -> r_v, i_ack, occ, acc_cnt go to 0 immediately without a clock edge. After release, the first new packet is acked normally.

Source files
------------

// File: rtl/noc_inject_port_pkg.sv
// Shared packet layout and field helpers for the NoC injection port.
package noc_pkg;

  localparam int unsigned VC_W = 2;
  localparam int unsigned X_W  = 2;
  localparam int unsigned Y_W  = 2;
  localparam int unsigned D_W  = 28;

  // Packet word: VC in the MSBs, then X, Y and payload.
  typedef struct packed {
    logic [VC_W-1:0] vc;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [D_W-1:0]  data;
  } pkt_t;

  function automatic pkt_t pkt_make(input logic [VC_W-1:0] vc,
                                    input logic [X_W-1:0]  x,
                                    input logic [Y_W-1:0]  y,
                                    input logic [D_W-1:0]  data);
    pkt_t p;
    p.vc   = vc;
    p.x    = x;
    p.y    = y;
    p.data = data;
    return p;
  endfunction

  function automatic logic [VC_W-1:0] pkt_vc(input pkt_t p);
    return p.vc;
  endfunction

  function automatic logic [X_W-1:0] pkt_x(input pkt_t p);
    return p.x;
  endfunction

  function automatic logic [Y_W-1:0] pkt_y(input pkt_t p);
    return p.y;
  endfunction

  function automatic logic [D_W-1:0] pkt_data(input pkt_t p);
    return p.data;
  endfunction

endpackage

// File: rtl/noc_inject_port_fifo.sv
// Show-ahead synchronous FIFO with separate occupancy tracking.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned OCC_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_pop;

  // Pop only a real head; push is pre-qualified by the caller.
  always_comb begin
    do_pop   = pop_i && (occ_q != '0);
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    if (push_i && !do_pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!push_i && do_pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage; cleared on reset so the head view reads zero when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/noc_inject_port.sv
// Router-side responder for the client i_v/i_ack injection handshake.
module noc_inject_port
  import noc_pkg::*;
#(
  parameter int unsigned VC_W  = noc_pkg::VC_W,
  parameter int unsigned X_W   = noc_pkg::X_W,
  parameter int unsigned Y_W   = noc_pkg::Y_W,
  parameter int unsigned D_W   = noc_pkg::D_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_v,
  input  logic [VC_W-1:0]        i_vc,
  input  logic [X_W-1:0]         i_x,
  input  logic [Y_W-1:0]         i_y,
  input  logic [D_W-1:0]         i_data,
  input  logic [VC_W-1:0]        i_b,
  output logic                   i_ack,
  output logic                   r_v,
  input  logic                   r_ready,
  output logic [VC_W-1:0]        r_vc,
  output logic [X_W-1:0]         r_x,
  output logic [Y_W-1:0]         r_y,
  output logic [D_W-1:0]         r_data,
  output logic [$clog2(DEPTH):0] occ,
  output logic [CNT_W-1:0]       acc_cnt,
  output logic                   busy
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned PKT_W = $bits(pkt_t);

  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] fifo_occ;
  logic [PKT_W-1:0] fifo_dout;
  pkt_t             in_pkt, head_pkt;
  logic             acc, pop;
  logic             unused_b;

  assign unused_b = |i_b;

  // Accept when offered, not in the ack (dead) cycle, and room exists
  // either now or via a same-edge pop.
  always_comb begin
    pop   = r_v && r_ready;
    acc   = i_v && !ack_q && ((fifo_occ < OCC_W'(DEPTH)) || pop);
    ack_d = acc;
    cnt_d = acc ? cnt_q + 1'b1 : cnt_q;
  end

  // Ack pulse and accepted-packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ack_q <= ack_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_pkt = pkt_make(i_vc, i_x, i_y, i_data);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (acc),
    .din_i  (in_pkt),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .occ_o  (fifo_occ)
  );

  assign head_pkt = pkt_t'(fifo_dout);
  assign r_v      = (fifo_occ != '0);
  assign r_vc     = pkt_vc(head_pkt);
  assign r_x      = pkt_x(head_pkt);
  assign r_y      = pkt_y(head_pkt);
  assign r_data   = pkt_data(head_pkt);
  assign occ      = fifo_occ;
  assign i_ack    = ack_q;
  assign acc_cnt  = cnt_q;
  assign busy     = (fifo_occ != '0) || ack_q;

endmodule

// File: tb/tb_noc_inject_port.sv
// Directed self-checking bench for noc_inject_port.
module tb_noc_inject_port;
  import noc_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_v;
  logic [1:0]  i_vc, i_x, i_y, i_b;
  logic [27:0] i_data;
  logic        i_ack;
  logic        r_v;
  logic        r_ready;
  logic [1:0]  r_vc, r_x, r_y;
  logic [27:0] r_data;
  logic [2:0]  occ;
  logic [15:0] acc_cnt;
  logic        busy;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int popped     = 0;
  bit rand_rdy   = 0;
  pkt_t exp_q[$];

  noc_inject_port #(
    .VC_W(2), .X_W(2), .Y_W(2), .D_W(28), .DEPTH(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_vc(i_vc), .i_x(i_x), .i_y(i_y),
    .i_data(i_data), .i_b(i_b), .i_ack(i_ack), .r_v(r_v), .r_ready(r_ready),
    .r_vc(r_vc), .r_x(r_x), .r_y(r_y), .r_data(r_data), .occ(occ),
    .acc_cnt(acc_cnt), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Router-side scoreboard: a head seen with r_ready at negedge departs on
  // the next rising edge.
  always @(negedge clk) begin
    if (rst && r_v && r_ready) begin
      pkt_t e;
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL departure: got %h but nothing expected", {r_vc, r_x, r_y, r_data});
      end else begin
        e = exp_q.pop_front();
        if ({r_vc, r_x, r_y, r_data} !== e) begin
          failures++;
          $display("FAIL departure: got %h expected %h", {r_vc, r_x, r_y, r_data}, e);
        end
        popped++;
      end
    end
  end

  function automatic pkt_t mk(input int n);
    pkt_t p;
    p.vc   = 2'(n);
    p.x    = 2'(n >> 2);
    p.y    = 2'(n >> 4);
    p.data = 28'h1000000 + 28'(n * 37);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) r_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input pkt_t p);
    i_v = 1'b1; i_vc = p.vc; i_x = p.x; i_y = p.y; i_data = p.data;
  endtask

  // Offer one packet; returns the cycle at which the ack became visible.
  task automatic send(input pkt_t p, input int maxc, output int ackcyc);
    bit got = 0;
    ackcyc = -1;
    drive(p);
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      if (i_ack) begin
        got = 1;
        ackcyc = cyc;
        exp_q.push_back(p);
      end
    end
    assertions++;
    if (!got) begin
      failures++;
      $display("FAIL send_ack: no ack within %0d cycles, expected 1", maxc);
    end
    i_v = 1'b0;
  endtask

  task automatic drain(input int maxc);
    r_ready = 1'b1;
    for (int i = 0; i < maxc && occ != 0; i++) tick();
    tick();
    assertions++;
    if (occ !== 3'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: occ=%0d pending=%0d, expected 0/0", occ, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 0; i_v = 0; i_vc = 0; i_x = 0; i_y = 0; i_data = 0; i_b = 0; r_ready = 0;
    #12;
    assertions++;
    if ({i_ack, r_v, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: ack/rv/busy=%b expected 000", {i_ack, r_v, busy});
    end
    assertions++;
    if (occ !== 3'd0 || acc_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts: occ=%0d cnt=%0d expected 0/0", occ, acc_cnt);
    end
    assertions++;
    if ({r_vc, r_x, r_y, r_data} !== 34'd0) begin
      failures++;
      $display("FAIL reset_head: got %h expected 0", {r_vc, r_x, r_y, r_data});
    end
    rst = 1;
    tick();
  endtask

  task automatic test_single();
    pkt_t p;
    p = pkt_make(2'd1, 2'd2, 2'd3, 28'hABCDEF0);
    r_ready = 1;
    drive(p);
    i_b = 2'd3;
    tick();
    assertions++;
    if (i_ack !== 1'b1 || r_v !== 1'b1 || occ !== 3'd1 || acc_cnt !== 16'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_ack: ack=%b rv=%b occ=%0d cnt=%0d busy=%b expected 1 1 1 1 1",
               i_ack, r_v, occ, acc_cnt, busy);
    end
    assertions++;
    if (r_vc !== 2'd1 || r_x !== 2'd2 || r_y !== 2'd3 || r_data !== 28'hABCDEF0) begin
      failures++;
      $display("FAIL single_head: got %h expected %h", {r_vc, r_x, r_y, r_data}, p);
    end
    exp_q.push_back(p);
    tick();
    assertions++;
    if (i_ack !== 1'b0 || occ !== 3'd0 || acc_cnt !== 16'd1 || r_v !== 1'b0) begin
      failures++;
      $display("FAIL held_iv: ack=%b occ=%0d cnt=%0d rv=%b expected 0 0 1 0",
               i_ack, occ, acc_cnt, r_v);
    end
    i_v = 0; i_b = 0;
    tick();
    assertions++;
    if (acc_cnt !== 16'd1 || busy !== 1'b0 || popped != 1) begin
      failures++;
      $display("FAIL single_idle: cnt=%0d busy=%b popped=%0d expected 1 0 1", acc_cnt, busy, popped);
    end
  endtask

  task automatic test_backpressure();
    int c0, ac;
    r_ready = 0;
    c0 = cyc;
    for (int k = 1; k <= 4; k++) begin
      send(mk(k), 10, ac);
      assertions++;
      if (ac != c0 + 2 * k - 1) begin
        failures++;
        $display("FAIL bp_ack_cycle%0d: ack at %0d expected %0d", k, ac - c0, 2 * k - 1);
      end
    end
    drive(mk(5));
    for (int i = 0; i < 4; i++) begin
      tick();
      assertions++;
      if (i_ack !== 1'b0) begin
        failures++;
        $display("FAIL full_no_ack: ack=%b expected 0", i_ack);
      end
    end
    assertions++;
    if (occ !== 3'd4 || acc_cnt !== 16'd5) begin
      failures++;
      $display("FAIL full_occ: occ=%0d cnt=%0d expected 4 5", occ, acc_cnt);
    end
    r_ready = 1;
    tick();
    assertions++;
    if (i_ack !== 1'b1 || occ !== 3'd4) begin
      failures++;
      $display("FAIL full_pop_accept: ack=%b occ=%0d expected 1 4", i_ack, occ);
    end
    exp_q.push_back(mk(5));
    i_v = 0;
    send(mk(6), 10, ac);
    drain(20);
    assertions++;
    if (acc_cnt !== 16'd7 || popped != 7) begin
      failures++;
      $display("FAIL bp_totals: cnt=%0d popped=%0d expected 7 7", acc_cnt, popped);
    end
  endtask

  task automatic test_wrap();
    int ac;
    rand_rdy = 1;
    for (int k = 0; k < 128; k++) send(mk(100 + k), 40, ac);
    rand_rdy = 0;
    drain(60);
    assertions++;
    if (acc_cnt !== 16'd135 || popped != 135) begin
      failures++;
      $display("FAIL wrap_totals: cnt=%0d popped=%0d expected 135 135", acc_cnt, popped);
    end
  endtask

  task automatic test_async_reset();
    int ac;
    r_ready = 0;
    for (int k = 0; k < 3; k++) send(mk(7 + k), 10, ac);
    assertions++;
    if (occ !== 3'd3 || i_ack !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: occ=%0d ack=%b expected 3 1", occ, i_ack);
    end
    #2 rst = 0;
    #1;
    assertions++;
    if (r_v !== 1'b0 || i_ack !== 1'b0 || occ !== 3'd0 || acc_cnt !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: rv=%b ack=%b occ=%0d cnt=%0d busy=%b expected 0 0 0 0 0",
               r_v, i_ack, occ, acc_cnt, busy);
    end
    exp_q.delete();
    popped = 0;
    #3 rst = 1;
    tick();
    send(mk(42), 5, ac);
    assertions++;
    if (acc_cnt !== 16'd1 || occ !== 3'd1 || r_data !== mk(42).data) begin
      failures++;
      $display("FAIL post_reset: cnt=%0d occ=%0d data=%h expected 1 1 %h",
               acc_cnt, occ, r_data, mk(42).data);
    end
    drain(10);
    assertions++;
    if (popped != 1) begin
      failures++;
      $display("FAIL post_reset_pop: popped=%0d expected 1", popped);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
